// File: rtl/alu_rs_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_rs_if                                                                  |
// | Dispatch, CDB snoop and ALU issue bundle around the ALU reservation station|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface alu_rs_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  logic                    flush;
  logic                    disp_valid;
  logic                    disp_ready;
  logic [2:0]              disp_funct3;
  logic                    disp_opt;
  logic [XLEN-1:0]         disp_a_val;
  logic [TAG_W-1:0]        disp_a_tag;
  logic                    disp_a_rdy;
  logic [XLEN-1:0]         disp_b_val;
  logic [TAG_W-1:0]        disp_b_tag;
  logic                    disp_b_rdy;
  logic [TAG_W-1:0]        disp_dest;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_data;
  logic                    alu_stall;
  logic                    iss_init;
  logic [XLEN-1:0]         iss_a;
  logic [XLEN-1:0]         iss_b;
  logic [2:0]              iss_funct3;
  logic                    iss_opt;
  logic [TAG_W-1:0]        iss_dest;
  logic [$clog2(DEPTH):0]  occupancy;

  modport slave (
    input  flush, disp_valid, disp_funct3, disp_opt,
           disp_a_val, disp_a_tag, disp_a_rdy,
           disp_b_val, disp_b_tag, disp_b_rdy, disp_dest,
           cdb_valid, cdb_tag, cdb_data, alu_stall,
    output disp_ready, iss_init, iss_a, iss_b, iss_funct3, iss_opt, iss_dest,
           occupancy
  );

  modport master (
    output flush, disp_valid, disp_funct3, disp_opt,
           disp_a_val, disp_a_tag, disp_a_rdy,
           disp_b_val, disp_b_tag, disp_b_rdy, disp_dest,
           cdb_valid, cdb_tag, cdb_data, alu_stall,
    input  disp_ready, iss_init, iss_a, iss_b, iss_funct3, iss_opt, iss_dest,
           occupancy
  );
endinterface
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_rs                                                                     |
// | Reservation station feeding the latched ALU; wakes operands from the CDB.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_rs #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  alu_rs_if.slave   rs
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_a_rdy;
  logic [DEPTH-1:0]  r_b_rdy;
  logic [DEPTH-1:0]  r_opt;
  logic [2:0]        r_funct3 [DEPTH];
  logic [TAG_W-1:0]  r_dest   [DEPTH];
  logic [TAG_W-1:0]  r_a_tag  [DEPTH];
  logic [TAG_W-1:0]  r_b_tag  [DEPTH];
  logic [XLEN-1:0]   r_a_val  [DEPTH];
  logic [XLEN-1:0]   r_b_val  [DEPTH];
  logic [OCC_W-1:0]  r_occ;

  logic [XLEN-1:0]   r_last_a;
  logic [XLEN-1:0]   r_last_b;
  logic [2:0]        r_last_funct3;
  logic              r_last_opt;
  logic [TAG_W-1:0]  r_last_dest;

  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic              w_any;
  logic [IDX_W-1:0]  w_sel;
  logic [IDX_W-1:0]  w_free;
  logic              w_issue;
  logic              w_disp;
  logic              w_a_bypass;
  logic              w_b_bypass;

  // Descending scan so the lowest index is the last one written.
  always_comb begin
    w_ready = r_valid & r_a_rdy & r_b_rdy;
    w_any   = 1'b0;
    w_sel   = '0;
    w_free  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_any = 1'b1;
        w_sel = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free = IDX_W'(i);
      end
    end
  end

  assign rs.disp_ready = (r_occ < C_DEPTH);
  assign w_issue       = w_any && !rs.alu_stall && !rs.flush;
  assign w_disp        = rs.disp_valid && rs.disp_ready && !rs.flush;
  assign w_a_bypass    = !rs.disp_a_rdy && rs.cdb_valid && (rs.cdb_tag == rs.disp_a_tag);
  assign w_b_bypass    = !rs.disp_b_rdy && rs.cdb_valid && (rs.cdb_tag == rs.disp_b_tag);

  // The free slot comes from registered valids, so a slot freed by this cycle's issue is not reused until next cycle.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_issue) w_valid_nxt[w_sel] = 1'b0;
    if (w_disp)  w_valid_nxt[w_free] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else if (rs.flush) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= r_occ + OCC_W'(w_disp) - OCC_W'(w_issue);
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk) begin
      if (w_disp && (w_free == IDX_W'(g))) begin
        r_funct3[g] <= rs.disp_funct3;
        r_opt[g]    <= rs.disp_opt;
        r_dest[g]   <= rs.disp_dest;
        r_a_tag[g]  <= rs.disp_a_tag;
        r_b_tag[g]  <= rs.disp_b_tag;
        r_a_rdy[g]  <= rs.disp_a_rdy || w_a_bypass;
        r_b_rdy[g]  <= rs.disp_b_rdy || w_b_bypass;
        r_a_val[g]  <= w_a_bypass ? rs.cdb_data : rs.disp_a_val;
        r_b_val[g]  <= w_b_bypass ? rs.cdb_data : rs.disp_b_val;
      end else begin
        if (r_valid[g] && !r_a_rdy[g] && rs.cdb_valid && (r_a_tag[g] == rs.cdb_tag)) begin
          r_a_val[g] <= rs.cdb_data;
          r_a_rdy[g] <= 1'b1;
        end
        if (r_valid[g] && !r_b_rdy[g] && rs.cdb_valid && (r_b_tag[g] == rs.cdb_tag)) begin
          r_b_val[g] <= rs.cdb_data;
          r_b_rdy[g] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_a      <= '0;
      r_last_b      <= '0;
      r_last_funct3 <= '0;
      r_last_opt    <= 1'b0;
      r_last_dest   <= '0;
    end else if (w_issue) begin
      r_last_a      <= r_a_val[w_sel];
      r_last_b      <= r_b_val[w_sel];
      r_last_funct3 <= r_funct3[w_sel];
      r_last_opt    <= r_opt[w_sel];
      r_last_dest   <= r_dest[w_sel];
    end
  end

  assign rs.iss_init   = w_issue;
  assign rs.iss_a      = w_issue ? r_a_val[w_sel]  : r_last_a;
  assign rs.iss_b      = w_issue ? r_b_val[w_sel]  : r_last_b;
  assign rs.iss_funct3 = w_issue ? r_funct3[w_sel] : r_last_funct3;
  assign rs.iss_opt    = w_issue ? r_opt[w_sel]    : r_last_opt;
  assign rs.iss_dest   = w_issue ? r_dest[w_sel]   : r_last_dest;
  assign rs.occupancy  = r_occ;
endmodule
`default_nettype wire

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the latched ALU.
- Buffers dispatched ALU ops until both source operands are available, snooping the common data bus (CDB) for missing values.
- Issues one ready op per cycle into the ALU using its init/operand/funct3/opt/destination interface.
- Sits between the dispatch/rename stage and the ALU functional unit.

Parameters:
XLEN, 32, operand/data width
DEPTH, 4, number of RS entries (power of 2, >=2)
TAG_W, 4, width of producer/destination tags (ROB index)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries (mispredict/exception)
disp_valid  input  1  dispatch request
disp_ready  output  1  at least one free entry (state-based, not combinational on this cycle's issue)
disp_funct3  input  3  ALU funct3
disp_opt  input  1  ALU opt (SUB/SRA select)
disp_a_val  input  XLEN  operand A value (valid when disp_a_rdy)
disp_a_tag  input  TAG_W  producer tag for A (used when !disp_a_rdy)
disp_a_rdy  input  1  operand A already available
disp_b_val  input  XLEN  operand B value
disp_b_tag  input  TAG_W  producer tag for B
disp_b_rdy  input  1  operand B already available
disp_dest  input  TAG_W  destination tag, forwarded to ALU as its address
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB producer tag
cdb_data  input  XLEN  CDB result value
alu_stall  input  1  ALU result slot occupied (ALU done && !ack); blocks issue
iss_init  output  1  issue strobe to ALU init
iss_a  output  XLEN  to ALU in_a
iss_b  output  XLEN  to ALU in_b
iss_funct3  output  3  to ALU funct3
iss_opt  output  1  to ALU opt
iss_dest  output  TAG_W  to ALU address input
occupancy  output  clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async, rst_n low): all entry valid bits 0, occupancy 0, disp_ready 1, iss_init 0, all iss_* data outputs 0. Reset mid-operation discards all entries.
- Entry fields: valid, funct3, opt, dest, a_val, a_tag, a_rdy, b_val, b_tag, b_rdy.
- Dispatch: accepted on a rising edge when disp_valid && disp_ready && !flush.
  - Written into the lowest-index free entry.
  - disp_ready = (occupancy < DEPTH), computed from registered state only.
- Dispatch-time bypass: if !disp_x_rdy and cdb_valid and cdb_tag == disp_x_tag in the same cycle, the entry stores cdb_data with x_rdy=1.
- Wakeup: each cycle, every valid entry with !x_rdy and x_tag == cdb_tag under cdb_valid captures cdb_data and sets x_rdy. A and B may wake in the same cycle from one broadcast.
- Select: entry is ready when valid && a_rdy && b_rdy (registered values). Among ready entries, the lowest index wins.
- Issue: combinational from entry storage.
  - iss_init = any ready entry && !alu_stall && !flush.
  - iss_* driven from the selected entry. When iss_init is 0, iss_* hold the last issued values (registered copy).
  - The issued entry's valid clears at the same edge.
- Latency:
  - Dispatch with both operands ready at cycle N: iss_init asserts in cycle N+1 at the earliest.
  - CDB wakeup in cycle N: issue in N+1 at the earliest. No same-cycle CDB-to-issue forwarding.
- Simultaneous issue and dispatch: both take effect. The freed slot is visible via disp_ready next cycle. Occupancy changes by +1, 0 or -1 accordingly.
- Full: disp_ready 0; disp_valid is ignored and the caller must hold the request.
- Empty: iss_init 0.
- Flush: at the edge, all valid bits clear and occupancy becomes 0. Flush wins over same-cycle dispatch and wakeup. iss_init is 0 during the flush cycle.
- alu_stall high: no entry leaves; wakeups and dispatch continue.
- Arithmetic: occupancy is a saturating-free counter and never exceeds DEPTH. A tag compare is an equality test only; no tag value is reserved.

Test Plan:
- Dispatch ADD (funct3=000, opt=0), a=5/b=7, both rdy, cycle 0 -> cycle 1: iss_init=1, iss_a=5, iss_b=7, iss_dest=disp_dest; occupancy 1 then 0.
- Dispatch SUB with b waiting on tag 3; CDB broadcasts tag 3 data 0x10 in cycle 4 -> iss_init in cycle 5 with iss_b=0x10, iss_opt=1. A second entry waiting on tag 2 stays unissued.
- Dispatch with a_tag=6 while cdb_tag=6 data 0xAA in the same cycle -> entry issues next cycle with iss_a=0xAA (bypass).
- Fill 4 entries with alu_stall=1 -> disp_ready=0, occupancy=4, no iss_init. Release stall -> issues in index order 0,1,2,3 on consecutive cycles; disp_ready returns to 1 the cycle after the first issue.
- 3 valid entries, assert flush together with disp_valid -> next cycle occupancy=0, disp_ready=1, no issue from flushed entries, dispatched op dropped.
- rst_n pulsed low asynchronously mid-wakeup with 2 entries -> immediately iss_init=0, occupancy=0, iss_a/iss_b=0; no issue after release until a new dispatch.
